// File: rtl/reel_speed_ramp.sv
// ============================================================================
// Module   : reel_speed_ramp
// Brief    : Reel speed profile generator feeding the reel clock divider.
//            Optional build macro AUTO_STOP_EN adds a timed HOLD exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reel_speed_ramp #(
    parameter int unsigned MIN_SPEED   = 1,
    parameter int unsigned TOP_SPEED   = 20,
    parameter int unsigned STEP        = 1,
    parameter int unsigned TICK_CYCLES = 5000000,
    parameter int unsigned HOLD_TICKS  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [25:0] speed,
    output logic        div_rst,
    output logic        spinning,
    output logic        settled
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_RAMP_UP   = 3'd1;
    localparam logic [2:0] c_HOLD      = 3'd2;
    localparam logic [2:0] c_RAMP_DOWN = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

    localparam int          c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [25:0] c_MIN    = 26'(MIN_SPEED);
    localparam logic [25:0] c_TOP    = 26'(TOP_SPEED);

    generate
        if (MIN_SPEED < 1 || TOP_SPEED < MIN_SPEED || TOP_SPEED > 32'h03FF_FFFF ||
            STEP < 1 || TICK_CYCLES < 1 || HOLD_TICKS > 32'h7FFF_FFFF) begin : g_param_check
            $error("reel_speed_ramp: illegal parameter combination");
        end
    endgenerate

    logic [2:0]          r_state;
    logic [25:0]         r_speed;
    logic                r_div_rst;
    logic                r_spinning;
    logic                r_settled;
    logic [c_TICK_W-1:0] r_tick_cnt;

    logic [2:0]  w_state_nxt;
    logic [25:0] w_speed_nxt;
    logic        w_state_chg;
    logic        w_tick;
    logic [26:0] w_up_sum;
    logic [25:0] w_speed_up;
    logic [25:0] w_speed_dn;
    logic        w_hold_done;

    assign w_tick = (r_tick_cnt == c_TICK_W'(TICK_CYCLES - 1));

    // Saturating arithmetic in 27 bits so neither direction can wrap.
    assign w_up_sum   = {1'b0, r_speed} + 27'(STEP);
    assign w_speed_up = (w_up_sum >= 27'(TOP_SPEED)) ? c_TOP : w_up_sum[25:0];
    assign w_speed_dn = ({1'b0, r_speed} >= (27'(MIN_SPEED) + 27'(STEP))) ?
                        (r_speed - 26'(STEP)) : c_MIN;

`ifdef AUTO_STOP_EN
    localparam int c_HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic [c_HOLD_W-1:0] r_hold_cnt;

    // HOLD_TICKS of 0 or 1 both expire on the first tick.
    assign w_hold_done = (32'(r_hold_cnt) + 32'd1) >= HOLD_TICKS;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if (r_state != c_HOLD || w_state_chg) begin
            r_hold_cnt <= '0;
        end else if (w_tick) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_hold_done = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        case (r_state)
            c_IDLE: begin
                w_speed_nxt = c_MIN;
                if (start) w_state_nxt = c_RAMP_UP;
            end
            c_RAMP_UP: begin
                if (stop) begin
                    w_state_nxt = c_RAMP_DOWN;
                end else if (w_tick) begin
                    w_speed_nxt = w_speed_up;
                    if (w_speed_up == c_TOP) w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                w_speed_nxt = c_TOP;
                if (stop || (w_tick && w_hold_done)) w_state_nxt = c_RAMP_DOWN;
            end
            c_RAMP_DOWN: begin
                if (w_tick) begin
                    w_speed_nxt = w_speed_dn;
                    if (w_speed_dn == c_MIN) w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_speed_nxt = c_MIN;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_speed_nxt = c_MIN;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_speed    <= c_MIN;
            r_div_rst  <= 1'b0;
            r_spinning <= 1'b0;
            r_settled  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_speed    <= w_speed_nxt;
            r_div_rst  <= (r_state == c_IDLE) && start;
            r_spinning <= (w_state_nxt == c_RAMP_UP) || (w_state_nxt == c_HOLD) ||
                          (w_state_nxt == c_RAMP_DOWN);
            r_settled  <= (w_state_nxt == c_DONE);
            // Every phase starts a full tick period after its entry edge.
            if (w_state_chg || w_tick || r_state == c_IDLE || r_state == c_DONE) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    assign speed    = r_speed;
    assign div_rst  = r_div_rst;
    assign spinning = r_spinning;
    assign settled  = r_settled;

endmodule

`default_nettype wire

// File: tb/tb_reel_speed_ramp.sv
// ============================================================================
// Module   : tb_reel_speed_ramp
// Brief    : Scoreboard bench for reel_speed_ramp (TICK_CYCLES=4, MIN=1,
//            TOP=4, STEP=2, HOLD_TICKS=2). Honours AUTO_STOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reel_speed_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [25:0] speed;
    logic        div_rst;
    logic        spinning;
    logic        settled;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [28:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [28:0] prev = {26'd1, 1'b0, 1'b0, 1'b0};

    reel_speed_ramp #(
        .MIN_SPEED  (1),
        .TOP_SPEED  (4),
        .STEP       (2),
        .TICK_CYCLES(4),
        .HOLD_TICKS (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .speed   (speed),
        .div_rst (div_rst),
        .spinning(spinning),
        .settled (settled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected output change: cycle of the edge that produces it plus values.
    function automatic void push_exp(input int c, input int spd, input logic d,
                                     input logic sp, input logic st);
        exp_t e;
        e.cyc = c;
        e.val = {26'(spd), d, sp, st};
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Monitor: every change of the output tuple must match the next queued entry.
    always @(negedge clk) begin
        logic [28:0] cur;
        exp_t        e;
        cur = {speed, div_rst, spinning, settled};
        if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d: got spd=%0d div=%0b spin=%0b set=%0b, required no change",
                         cyc, cur[28:3], cur[2], cur[1], cur[0]);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    errors++;
                    $display("FAIL output_change: got cyc=%0d spd=%0d div=%0b spin=%0b set=%0b, required cyc=%0d spd=%0d div=%0b spin=%0b set=%0b",
                             cyc, cur[28:3], cur[2], cur[1], cur[0],
                             e.cyc, e.val[28:3], e.val[2], e.val[1], e.val[0]);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int s;
        int x;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_speed", 32'(speed), 32'd1);
        chk("reset_spinning", 32'(spinning), 32'd0);
        chk("reset_div_rst", 32'(div_rst), 32'd0);
        chk("reset_settled", 32'(settled), 32'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("release_speed", 32'(speed), 32'd1);
        for (int i = 0; i < 4; i++) begin
            stop = ~stop;
            @(negedge clk);
        end
        stop = 1'b0;
        chk("idle_stop_speed", 32'(speed), 32'd1);
        chk("idle_stop_spinning", 32'(spinning), 32'd0);

        // Spin up to HOLD
        e = cyc + 1;
        push_exp(e, 1, 1, 1, 0);
        push_exp(e + 1, 1, 0, 1, 0);
        push_exp(e + 4, 3, 0, 1, 0);
        push_exp(e + 8, 4, 0, 1, 0);
        pulse_start();
        wait_until(e + 10);

        // Stop from HOLD; start during DONE is ignored
        s = cyc + 1;
        push_exp(s + 4, 2, 0, 1, 0);
        push_exp(s + 8, 1, 0, 0, 1);
        push_exp(s + 9, 1, 0, 0, 0);
        pulse_stop();
        wait_until(s + 8);
        pulse_start();
        wait_until(s + 12);

        // Stop at speed 3 coincident with a tick; starts during ramp-down ignored
        e = cyc + 1;
        push_exp(e, 1, 1, 1, 0);
        push_exp(e + 1, 1, 0, 1, 0);
        push_exp(e + 4, 3, 0, 1, 0);
        push_exp(e + 12, 1, 0, 0, 1);
        push_exp(e + 13, 1, 0, 0, 0);
        pulse_start();
        wait_until(e + 7);
        pulse_stop();
        wait_until(e + 9);
        pulse_start();
        wait_until(e + 11);
        pulse_start();
        wait_until(e + 16);

        // Asynchronous reset in the middle of RAMP_DOWN
        e = cyc + 1;
        push_exp(e, 1, 1, 1, 0);
        push_exp(e + 1, 1, 0, 1, 0);
        push_exp(e + 4, 3, 0, 1, 0);
        push_exp(e + 8, 4, 0, 1, 0);
        pulse_start();
        wait_until(e + 9);
        push_exp(e + 14, 2, 0, 1, 0);
        pulse_stop();
        wait_until(e + 15);
        push_exp(e + 16, 1, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_speed", 32'(speed), 32'd1);
        chk("async_rst_spinning", 32'(spinning), 32'd0);
        wait_until(e + 18);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh start after reset, stopped at MIN_SPEED right away
        e = cyc + 1;
        push_exp(e, 1, 1, 1, 0);
        push_exp(e + 1, 1, 0, 1, 0);
        push_exp(e + 5, 1, 0, 0, 1);
        push_exp(e + 6, 1, 0, 0, 0);
        pulse_start();
        pulse_stop();
        wait_until(e + 8);

        // HOLD without any stop request
        e = cyc + 1;
        push_exp(e, 1, 1, 1, 0);
        push_exp(e + 1, 1, 0, 1, 0);
        push_exp(e + 4, 3, 0, 1, 0);
        push_exp(e + 8, 4, 0, 1, 0);
`ifdef AUTO_STOP_EN
        push_exp(e + 20, 2, 0, 1, 0);
        push_exp(e + 24, 1, 0, 0, 1);
        push_exp(e + 25, 1, 0, 0, 0);
        pulse_start();
        wait_until(e + 27);
        chk("auto_stop_idle_speed", 32'(speed), 32'd1);
`else
        pulse_start();
        wait_until(e + 1008);
        chk("hold_persist_speed", 32'(speed), 32'd4);
        chk("hold_persist_spinning", 32'(spinning), 32'd1);
        x = cyc + 1;
        push_exp(x + 4, 2, 0, 1, 0);
        push_exp(x + 8, 1, 0, 0, 1);
        push_exp(x + 9, 1, 0, 0, 0);
        pulse_stop();
        wait_until(x + 11);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
